// File: rtl/down_counter_if.sv
// Control, counter-status and terminal-count event signals of down_counter.
// master drives the strobes and accepts events; slave is the counter itself.
interface down_counter_if #(
  parameter int WIDTH = 8
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             dec;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             uflow;
  logic             evt_valid;
  logic             evt_ready;
  logic             evt_miss;

  modport master (
    output clr, load, load_val, dec, evt_ready,
    input  out, zero, uflow, evt_valid, evt_miss
  );

  modport slave (
    input  clr, load, load_val, dec, evt_ready,
    output out, zero, uflow, evt_valid, evt_miss
  );
endinterface

// File: rtl/down_counter.sv
// Loadable down-counter that consumes credits on dec strobes.
// Reaching zero raises a terminal-count event held until the consumer takes it.
module down_counter #(
  parameter int WIDTH = 8,
  parameter bit WRAP  = 1'b1
) (
  input  logic          aclk,
  input  logic          arstn,
  down_counter_if.slave bus
);
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             uflow_q, uflow_d;
  logic             evt_valid_q, evt_valid_d;
  logic             evt_miss_q, evt_miss_d;
  logic             evt_new;
  logic             evt_xfer;

  // Counter action: clr beats load beats dec, one action per edge.
  always_comb begin
    out_d   = out_q;
    zero_d  = zero_q;
    uflow_d = 1'b0;
    evt_new = 1'b0;
    if (bus.clr) begin
      out_d  = '0;
      zero_d = 1'b1;
    end else if (bus.load) begin
      out_d  = bus.load_val;
      zero_d = (bus.load_val == '0);
    end else if (bus.dec) begin
      if (out_q == '0) begin
        uflow_d = 1'b1;
        if (WRAP) begin
          out_d  = '1;
          zero_d = 1'b0;
        end
      end else if (out_q == WIDTH'(1)) begin
        out_d   = '0;
        zero_d  = 1'b1;
        evt_new = 1'b1;
      end else begin
        out_d  = out_q - WIDTH'(1);
        zero_d = 1'b0;
      end
    end
  end

  // A fresh event overwrites a just-transferred one; colliding with an
  // untaken one drops the newcomer and latches the miss flag.
  always_comb begin
    evt_xfer    = evt_valid_q & bus.evt_ready;
    evt_valid_d = evt_new | (evt_valid_q & ~evt_xfer);
    evt_miss_d  = evt_miss_q;
    if (bus.clr)
      evt_miss_d = 1'b0;
    else if (evt_new && evt_valid_q && !evt_xfer)
      evt_miss_d = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      out_q       <= '0;
      zero_q      <= 1'b1;
      uflow_q     <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_miss_q  <= 1'b0;
    end else begin
      out_q       <= out_d;
      zero_q      <= zero_d;
      uflow_q     <= uflow_d;
      evt_valid_q <= evt_valid_d;
      evt_miss_q  <= evt_miss_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.zero      = zero_q;
  assign bus.uflow     = uflow_q;
  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_miss  = evt_miss_q;
endmodule

// File: tb/tb_down_counter.sv
// Drives a wrapping and a saturating down_counter with the same stimulus and
// checks both against a credit/event model every cycle plus directed literals.
module tb_down_counter;
  logic       aclk = 1'b0;
  logic       arstn, clr, load, dec, evt_ready;
  logic [7:0] load_val;

  down_counter_if #(.WIDTH(8)) bw ();
  down_counter_if #(.WIDTH(8)) bs ();

  assign bw.clr = clr;  assign bw.load = load;  assign bw.load_val = load_val;
  assign bw.dec = dec;  assign bw.evt_ready = evt_ready;
  assign bs.clr = clr;  assign bs.load = load;  assign bs.load_val = load_val;
  assign bs.dec = dec;  assign bs.evt_ready = evt_ready;

  down_counter #(.WIDTH(8), .WRAP(1'b1)) u_wrap (.aclk(aclk), .arstn(arstn), .bus(bw));
  down_counter #(.WIDTH(8), .WRAP(1'b0)) u_sat  (.aclk(aclk), .arstn(arstn), .bus(bs));

  always #5 aclk = ~aclk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: index 0 wraps, index 1 saturates.
  int m_cnt   [2];
  bit m_valid [2];
  bit m_miss  [2];
  bit m_uflow [2];

  always @(posedge aclk) begin
    for (int k = 0; k < 2; k++) begin
      automatic int c = m_cnt[k];
      automatic bit v = m_valid[k];
      automatic bit m = m_miss[k];
      automatic bit u = 1'b0;
      automatic bit ev = 1'b0;
      automatic bit taken;
      if (!arstn) begin
        c = 0; v = 0; m = 0;
      end else begin
        if (clr) begin
          c = 0; m = 0;
        end else if (load) begin
          c = int'(load_val);
        end else if (dec) begin
          if (c == 0) begin
            u = 1'b1;
            c = (k == 0) ? 255 : 0;
          end else begin
            c = c - 1;
            ev = (c == 0);
          end
        end
        taken = v && evt_ready;
        if (ev && v && !taken) m = 1'b1;
        v = ev || (v && !taken);
      end
      m_cnt[k]   <= c;
      m_valid[k] <= v;
      m_miss[k]  <= m;
      m_uflow[k] <= u;
    end
  end

  always @(negedge aclk) begin
    if (chk_en) begin
      chk("wrap.out",       bw.out,       m_cnt[0]);
      chk("wrap.zero",      bw.zero,      m_cnt[0] == 0);
      chk("wrap.uflow",     bw.uflow,     m_uflow[0]);
      chk("wrap.evt_valid", bw.evt_valid, m_valid[0]);
      chk("wrap.evt_miss",  bw.evt_miss,  m_miss[0]);
      chk("sat.out",        bs.out,       m_cnt[1]);
      chk("sat.zero",       bs.zero,      m_cnt[1] == 0);
      chk("sat.uflow",      bs.uflow,     m_uflow[1]);
      chk("sat.evt_valid",  bs.evt_valid, m_valid[1]);
      chk("sat.evt_miss",   bs.evt_miss,  m_miss[1]);
    end
  end

  // Apply one cycle of inputs, then return 1ns after the sampling edge.
  task automatic step(input bit rn, input bit c, input bit l, input logic [7:0] lv,
                      input bit d, input bit r);
    arstn = rn; clr = c; load = l; load_val = lv; dec = d; evt_ready = r;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    arstn = 0; clr = 0; load = 0; load_val = 0; dec = 0; evt_ready = 0;

    // Reset with load asserted
    step(0, 0, 1, 8'd5, 0, 0);
    chk_en = 1'b1;
    step(0, 0, 1, 8'd5, 0, 0);
    step(0, 0, 1, 8'd5, 0, 0);
    chk("rst.out", bw.out, 0);
    chk("rst.zero", bw.zero, 1);
    chk("rst.evt_valid", bw.evt_valid, 0);
    chk("rst.evt_miss", bw.evt_miss, 0);
    chk("rst.uflow", bw.uflow, 0);

    // Countdown with held event
    step(1, 0, 1, 8'd3, 0, 0);
    chk("cd.load", bw.out, 3);
    step(1, 0, 0, 0, 1, 0);  chk("cd.out2", bw.out, 2);
    step(1, 0, 0, 0, 1, 0);  chk("cd.out1", bw.out, 1);
    chk("cd.novalid", bw.evt_valid, 0);
    step(1, 0, 0, 0, 1, 0);  chk("cd.out0", bw.out, 0);
    chk("cd.valid", bw.evt_valid, 1);
    chk("cd.zero", bw.zero, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
    chk("cd.hold", bw.evt_valid, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("cd.taken", bw.evt_valid, 0);

    // Underflow from zero
    step(1, 0, 0, 0, 1, 0);
    chk("uf.wrap_out", bw.out, 255);
    chk("uf.wrap_zero", bw.zero, 0);
    chk("uf.wrap_pulse", bw.uflow, 1);
    chk("uf.sat_out", bs.out, 0);
    chk("uf.sat_pulse", bs.uflow, 1);
    chk("uf.noevt", bw.evt_valid, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("uf.pulse_end", bw.uflow, 0);

    // Priority clr > load > dec
    step(1, 0, 1, 8'd10, 0, 0);
    step(1, 1, 1, 8'd7, 1, 0);  chk("pri.clr", bw.out, 0);
    step(1, 0, 1, 8'd7, 1, 0);  chk("pri.load", bw.out, 7);
    step(1, 0, 0, 0, 1, 0);     chk("pri.dec", bw.out, 6);

    // Missed event, then clr clears the sticky flag
    step(1, 0, 1, 8'd1, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 1, 8'd1, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    chk("miss.set", bw.evt_miss, 1);
    chk("miss.valid", bw.evt_valid, 1);
    step(1, 1, 0, 0, 0, 0);
    chk("miss.clr", bw.evt_miss, 0);
    chk("miss.clr_valid", bw.evt_valid, 1);
    step(1, 0, 0, 0, 0, 1);
    // Collision with a transfer on the same edge is not a miss
    step(1, 0, 1, 8'd1, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 1, 8'd1, 0, 0);
    step(1, 0, 0, 0, 1, 1);
    chk("nomiss.miss", bw.evt_miss, 0);
    chk("nomiss.valid", bw.evt_valid, 1);
    step(1, 1, 0, 0, 0, 0);
    chk("nomiss.clr", bw.evt_miss, 0);
    step(1, 0, 0, 0, 0, 1);

    // Reset in the middle of a count
    step(1, 0, 1, 8'd200, 0, 0);
    for (int i = 0; i < 50; i++) step(1, 0, 0, 0, 1, 0);
    chk("mid.out150", bw.out, 150);
    step(0, 0, 0, 0, 1, 0);
    chk("mid.rst_out", bw.out, 0);
    chk("mid.rst_valid", bw.evt_valid, 0);
    step(1, 0, 0, 0, 1, 0);
    chk("mid.uflow", bw.uflow, 1);
    chk("mid.wrap", bw.out, 255);

    // Random traffic; small load values keep events frequent
    for (int i = 0; i < 3000; i++) begin
      automatic bit rn = ($urandom_range(0, 199) != 0);
      automatic bit c  = ($urandom_range(0, 31) == 0);
      automatic bit l  = ($urandom_range(0, 7) == 0);
      automatic logic [7:0] lv = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 4))
                                                             : 8'($urandom);
      automatic bit d  = ($urandom_range(0, 1) != 0);
      automatic bit r  = ($urandom_range(0, 2) == 0);
      step(rn, c, l, lv, d, r);
    end

    @(negedge aclk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
- Loadable down-counter; the decrementing counterpart of the team's incrementing Adder counter.
- Counts a preloaded value down on `dec` strobes.
- Flags underflow and signals each terminal-count (reach-zero) event to a consumer over a valid/ready handshake.
- Sits beside Adder in timer/credit logic: Adder counts events up, this block consumes credits down.

Parameters:
- WIDTH, 8, bit width of counter and load value.
- WRAP, 1, 1 = wrap to 2^WIDTH-1 on underflow; 0 = saturate at 0.

Ports:
- aclk  input  1  clock; all state updates on rising edge.
- arstn  input  1  synchronous active-low reset, sampled on rising edge of aclk.
- clr  input  1  synchronous clear of counter and sticky flag.
- load  input  1  load strobe.
- load_val  input  WIDTH  value captured when load=1.
- dec  input  1  decrement strobe, one step per cycle high.
- out  output  WIDTH  registered counter value.
- zero  output  1  registered; 1 when out==0.
- uflow  output  1  one-cycle pulse when dec is applied with out==0.
- evt_valid  output  1  terminal-count event pending.
- evt_ready  input  1  consumer accepts event.
- evt_miss  output  1  sticky; a new event arrived while one was already pending and not accepted.

Behaviour:
- Reset: arstn=0 at a rising edge gives out=0, zero=1, uflow=0, evt_valid=0, evt_miss=0. Reset overrides all other inputs. Asserting it mid-count discards pending events.
- Counter priority per edge: clr > load > dec. Exactly one counter action per cycle.
- clr=1: out<=0, zero<=1, evt_miss<=0. No event generated, no uflow pulse.
  - evt_valid is unaffected, except the normal handshake still completes.
- load=1 (clr=0): out<=load_val; zero<=(load_val==0). dec in the same cycle is ignored. Loading 0 does not generate an event.
- dec=1, out>1: out<=out-1.
- dec=1, out==1: out<=0, zero<=1. Terminal-count event generated at the same edge.
- dec=1, out==0: uflow<=1 for one cycle.
  - WRAP=1: out<=2^WIDTH-1, zero<=0.
  - WRAP=0: out stays 0.
  - No terminal-count event is generated.
- uflow is 0 in every cycle not described above.
- Event handshake:
  - A transfer occurs at an edge where evt_valid=1 and evt_ready=1; evt_valid then clears unless a new event arrives at the same edge.
  - evt_valid stays high, independent of evt_ready, until transferred.
  - evt_ready while evt_valid=0 has no effect.
- New event at an edge with evt_valid=1:
  - With transfer at that edge: evt_valid stays 1 for the new event; evt_miss unchanged.
  - Without transfer: evt_valid stays 1 and evt_miss<=1. The second event is lost.
- Latency: all outputs are registered; the effect of any input appears after the edge that samples it.
- Arithmetic: unsigned modulo 2^WIDTH. out==2^WIDTH-1 is valid and loadable.

Test Plan:
- Reset: hold arstn=0 for 3 edges with load=1, load_val=8'd5 -> out=0, zero=1, evt_valid=0, evt_miss=0, uflow=0.
- Countdown with handshake: load 8'd3, then dec for 3 cycles with evt_ready=0 -> out 3,2,1,0; evt_valid=1 and zero=1 at the third edge. evt_valid holds for 4 idle cycles, then clears one edge after evt_ready=1.
- Underflow, WRAP=1 and WIDTH=8: out=0, dec for one cycle -> out=255, zero=0, uflow=1 for exactly one cycle, evt_valid unchanged. Repeat with WRAP=0 -> out=0, uflow pulse.
- Priority: out=10 with clr=1, load=1 (load_val=7), dec=1 -> out=0. Then load=1 (load_val=7), dec=1 -> out=7. Then dec only -> out=6.
- Event miss: load 1, dec (event pending, evt_ready=0), load 1, dec -> evt_miss=1, evt_valid=1. Repeat with evt_ready=1 at the second reach-zero edge -> evt_miss stays 0, evt_valid=1. clr -> evt_miss=0.
- Reset mid-operation: load 8'd200, dec for 50 cycles, assert arstn=0 for one edge while dec=1 -> out=0, evt_valid=0. After release, dec -> uflow=1 and out=255 (WRAP=1).
